// File: rtl/grid_overlay_gen.sv
// rtl/grid_overlay_gen.sv - oscilloscope graticule, cursor and background overlay, 2-stage pipeline
//
// Purpose: draws the dashed plot frame, unit grid and a cursor pair over the
// plot area and paints the surround with the background colour. Stage 1
// registers the pixel position and tracks the in-division offsets with
// counters; stage 2 resolves colour priority and registers the outputs.
// Optional feature: define GRID_CENTER_AXIS_EN for solid centre axes with ticks.
//
// Ports:
//   clk_grid, rst_grid           pixel clock, synchronous active-high reset
//   xpos_grid, ypos_grid         current pixel position (12 bit)
//   color_grid/back/cur/axis     colour inputs (CW bit)
//   cur_wr, cur_x, cur_y, cur_on cursor shadow write strobe and values
//   cur_pend                     shadow written but not yet applied
//   grid_hit, data_grid          line-pixel flag and pixel colour, 2 clk after position

module grid_overlay_gen #(
   parameter int H_DISP    = 800,
   parameter int V_DISP    = 600,
   parameter int BORDER    = 44,
   parameter int SCR_W     = 512,
   parameter int SCR_H     = 512,
   parameter int WORD_AREA = 200,
   parameter int UNIT      = 64,
   parameter int DASH_LOG2 = 2,
   parameter int CW        = 16
) (
   input  logic          clk_grid,
   input  logic          rst_grid,
   input  logic [11:0]   xpos_grid,
   input  logic [11:0]   ypos_grid,
   input  logic [CW-1:0] color_grid,
   input  logic [CW-1:0] color_back,
   input  logic [CW-1:0] color_cur,
   input  logic [CW-1:0] color_axis,
   input  logic          cur_wr,
   input  logic [11:0]   cur_x,
   input  logic [11:0]   cur_y,
   input  logic          cur_on,
   output logic          cur_pend,
   output logic          grid_hit,
   output logic [CW-1:0] data_grid
);

   localparam int UW = $clog2(UNIT);

   localparam logic [11:0] X_BEG  = 12'(BORDER);
   localparam logic [11:0] X_PEND = 12'(BORDER + SCR_W);
   localparam logic [11:0] X_FEND = 12'(BORDER + SCR_W + WORD_AREA);
   localparam logic [11:0] Y_BEG  = 12'(BORDER);
   localparam logic [11:0] Y_PEND = 12'(BORDER + SCR_H);
   localparam logic [11:0] H_END  = 12'(H_DISP);
   localparam logic [11:0] V_END  = 12'(V_DISP);

   // stage 1 state
   logic [11:0]   x1_q, y1_q;
   logic          v1_q, v1_d;
   logic [UW-1:0] x_off_q, x_off_d;
   logic [UW-1:0] y_off_q, y_off_d;

   // cursor shadow / active
   logic [11:0]   sh_x_q, sh_y_q, act_x_q, act_y_q;
   logic          sh_on_q, act_on_q, cur_pend_q;

   // stage 2 outputs
   logic [CW-1:0] data_q, data_d;
   logic          hit_q, hit_d;

   logic frame_start;
   assign frame_start = (xpos_grid == 12'd0) && (ypos_grid == 12'd0);

   // Offsets rely on xpos stepping by one per clock and on every line
   // starting at xpos 0, so no divider is needed.
   always_comb begin
      v1_d    = (xpos_grid < H_END) && (ypos_grid < V_END);
      x_off_d = '0;
      if ((xpos_grid > X_BEG) && (xpos_grid <= X_PEND))
         x_off_d = x_off_q + 1'b1;
      y_off_d = y_off_q;
      if (xpos_grid == 12'd0)
         y_off_d = (ypos_grid == Y_BEG) ? '0 : y_off_q + 1'b1;
   end

   always_ff @(posedge clk_grid) begin
      if (rst_grid) begin
         x1_q    <= '0;
         y1_q    <= '0;
         v1_q    <= 1'b0;
         x_off_q <= '0;
         y_off_q <= '0;
      end else begin
         x1_q    <= xpos_grid;
         y1_q    <= ypos_grid;
         v1_q    <= v1_d;
         x_off_q <= x_off_d;
         y_off_q <= y_off_d;
      end
   end

   // A write on the frame-start cycle bypasses the shadow so it takes effect
   // in the frame that is just beginning.
   always_ff @(posedge clk_grid) begin
      if (rst_grid) begin
         sh_x_q     <= '0;
         sh_y_q     <= '0;
         sh_on_q    <= 1'b0;
         act_x_q    <= '0;
         act_y_q    <= '0;
         act_on_q   <= 1'b0;
         cur_pend_q <= 1'b0;
      end else if (frame_start) begin
         cur_pend_q <= 1'b0;
         if (cur_wr) begin
            sh_x_q   <= cur_x;
            sh_y_q   <= cur_y;
            sh_on_q  <= cur_on;
            act_x_q  <= cur_x;
            act_y_q  <= cur_y;
            act_on_q <= cur_on;
         end else begin
            act_x_q  <= sh_x_q;
            act_y_q  <= sh_y_q;
            act_on_q <= sh_on_q;
         end
      end else if (cur_wr) begin
         sh_x_q     <= cur_x;
         sh_y_q     <= cur_y;
         sh_on_q    <= cur_on;
         cur_pend_q <= 1'b1;
      end
   end

   // stage 2 decode
   logic        in_plot, cur_hit, hframe_hit, vline_hit, hgrid_hit, outside;
   logic [12:0] cur_vx, cur_vy;

   // 13-bit sums so an out-of-range cursor offset can never alias into the plot
   assign cur_vx = 13'(BORDER) + {1'b0, act_x_q};
   assign cur_vy = 13'(BORDER) + {1'b0, act_y_q};

   assign in_plot = (x1_q >= X_BEG) && (x1_q < X_PEND) && (y1_q >= Y_BEG) && (y1_q < Y_PEND);

   assign cur_hit = act_on_q && in_plot &&
                    (({1'b0, x1_q} == cur_vx) || ({1'b0, y1_q} == cur_vy));

   assign hframe_hit = ((y1_q == Y_BEG) || (y1_q == Y_PEND)) &&
                       (x1_q >= X_BEG) && (x1_q <= X_FEND) && x1_q[DASH_LOG2];

   assign vline_hit = (((x_off_q == '0) && (x1_q >= X_BEG) && (x1_q <= X_PEND)) ||
                       (x1_q == X_FEND)) &&
                      (y1_q >= Y_BEG) && (y1_q < Y_PEND) && y1_q[DASH_LOG2];

   assign hgrid_hit = (y_off_q == '0) && (y1_q > Y_BEG) && (y1_q < Y_PEND) &&
                      (x1_q >= X_BEG) && (x1_q < X_PEND) && x1_q[DASH_LOG2];

   assign outside = (x1_q < X_BEG) || (x1_q > X_FEND) || (y1_q < Y_BEG) || (y1_q > Y_PEND);

`ifdef GRID_CENTER_AXIS_EN
   localparam int          TKB     = $clog2(UNIT / 4);
   localparam logic [11:0] AX_X    = 12'(BORDER + SCR_W / 2);
   localparam logic [11:0] AX_Y    = 12'(BORDER + SCR_H / 2);
   localparam logic [11:0] AX_X_LO = 12'(BORDER + SCR_W / 2 - 3);
   localparam logic [11:0] AX_X_HI = 12'(BORDER + SCR_W / 2 + 3);
   localparam logic [11:0] AX_Y_LO = 12'(BORDER + SCR_H / 2 - 3);
   localparam logic [11:0] AX_Y_HI = 12'(BORDER + SCR_H / 2 + 3);

   logic axis_hit, tick_v, tick_h;

   // Offsets modulo UNIT also give the UNIT/4 tick phase from their low bits.
   assign tick_v   = (y_off_q[TKB-1:0] == '0) && (x1_q >= AX_X_LO) && (x1_q <= AX_X_HI);
   assign tick_h   = (x_off_q[TKB-1:0] == '0) && (y1_q >= AX_Y_LO) && (y1_q <= AX_Y_HI);
   assign axis_hit = in_plot && ((x1_q == AX_X) || (y1_q == AX_Y) || tick_v || tick_h);
`else
   logic unused_axis;
   assign unused_axis = ^color_axis;
`endif

   always_comb begin
      data_d = '0;
      hit_d  = 1'b0;
      if (!v1_q) begin
         data_d = '0;
      end else if (cur_hit) begin
         data_d = color_cur;
         hit_d  = 1'b1;
`ifdef GRID_CENTER_AXIS_EN
      end else if (axis_hit) begin
         data_d = color_axis;
         hit_d  = 1'b1;
`endif
      end else if (hframe_hit || vline_hit || hgrid_hit) begin
         data_d = color_grid;
         hit_d  = 1'b1;
      end else if (outside) begin
         data_d = color_back;
      end
   end

   always_ff @(posedge clk_grid) begin
      if (rst_grid) begin
         data_q <= '0;
         hit_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         hit_q  <= hit_d;
      end
   end

   assign data_grid = data_q;
   assign grid_hit  = hit_q;
   assign cur_pend  = cur_pend_q;

endmodule

// File: tb/tb_grid_overlay_gen.sv
// tb/tb_grid_overlay_gen.sv - directed-vector bench for grid_overlay_gen

module tb_grid_overlay_gen;

   localparam logic [15:0] C_GRID = 16'h07E0;
   localparam logic [15:0] C_BACK = 16'h001F;
   localparam logic [15:0] C_CUR  = 16'hF800;
   localparam logic [15:0] C_AXIS = 16'hFFE0;

   logic        clk_grid = 1'b0;
   logic        rst_grid;
   logic [11:0] xpos_grid, ypos_grid;
   logic [15:0] color_grid, color_back, color_cur, color_axis;
   logic        cur_wr;
   logic [11:0] cur_x, cur_y;
   logic        cur_on;
   logic        cur_pend, grid_hit;
   logic [15:0] data_grid;

   int n_vec = 0;
   int n_err = 0;

   grid_overlay_gen dut (
      .clk_grid   (clk_grid),
      .rst_grid   (rst_grid),
      .xpos_grid  (xpos_grid),
      .ypos_grid  (ypos_grid),
      .color_grid (color_grid),
      .color_back (color_back),
      .color_cur  (color_cur),
      .color_axis (color_axis),
      .cur_wr     (cur_wr),
      .cur_x      (cur_x),
      .cur_y      (cur_y),
      .cur_on     (cur_on),
      .cur_pend   (cur_pend),
      .grid_hit   (grid_hit),
      .data_grid  (data_grid)
   );

   always #5 clk_grid = ~clk_grid;

   // one pixel per clock; after step(P) then step(P+1) the outputs show P
   task automatic step(input int x, input int y);
      xpos_grid = 12'(x);
      ypos_grid = 12'(y);
      @(posedge clk_grid);
      #1;
      cur_wr = 1'b0;
   endtask

   task automatic lines(input int y0, input int y1);
      for (int y = y0; y <= y1; y++) step(0, y);
   endtask

   task automatic run_x(input int y, input int x0, input int x1);
      for (int x = x0; x <= x1; x++) step(x, y);
   endtask

   task automatic test_reset;
      rst_grid = 1'b1;
      step(100, 200); step(101, 200); step(102, 200);
      n_vec++; if (data_grid !== 16'h0) begin $display("FAIL rst_data got=%h exp=0000", data_grid); n_err++; end
      n_vec++; if (grid_hit !== 1'b0) begin $display("FAIL rst_hit got=%b exp=0", grid_hit); n_err++; end
      n_vec++; if (cur_pend !== 1'b0) begin $display("FAIL rst_pend got=%b exp=0", cur_pend); n_err++; end
      rst_grid = 1'b0;
   endtask

   task automatic test_scan;
      step(0, 0);
      lines(44, 44); run_x(44, 44, 45);
      n_vec++; if (data_grid !== C_GRID || grid_hit !== 1'b1) begin $display("FAIL frame_44_44 got=%h/%b exp=%h/1", data_grid, grid_hit, C_GRID); n_err++; end
      run_x(44, 46, 107);
      n_vec++; if (data_grid !== 16'h0 || grid_hit !== 1'b0) begin $display("FAIL frame_106_44 got=%h/%b exp=0000/0", data_grid, grid_hit); n_err++; end
      run_x(44, 108, 110);
      n_vec++; if (data_grid !== C_GRID) begin $display("FAIL frame_109_44 got=%h exp=%h", data_grid, C_GRID); n_err++; end
      lines(45, 45); run_x(45, 44, 108);
      n_vec++; if (data_grid !== 16'h0) begin $display("FAIL lag_107_45 got=%h exp=0000", data_grid); n_err++; end
      step(109, 45);
      n_vec++; if (data_grid !== C_GRID || grid_hit !== 1'b1) begin $display("FAIL vline_108_45 got=%h/%b exp=%h/1", data_grid, grid_hit, C_GRID); n_err++; end
      run_x(45, 110, 757);
      n_vec++; if (data_grid !== C_GRID) begin $display("FAIL right_756_45 got=%h exp=%h", data_grid, C_GRID); n_err++; end
      step(758, 45);
      n_vec++; if (data_grid !== C_BACK || grid_hit !== 1'b0) begin $display("FAIL out_757_45 got=%h/%b exp=%h/0", data_grid, grid_hit, C_BACK); n_err++; end
      lines(46, 300); run_x(300, 20, 21);
      n_vec++; if (data_grid !== C_BACK || grid_hit !== 1'b0) begin $display("FAIL back_20_300 got=%h/%b exp=%h/0", data_grid, grid_hit, C_BACK); n_err++; end
      lines(301, 301); run_x(301, 44, 301);
      n_vec++; if (data_grid !== C_GRID) begin $display("FAIL vline_300_301 got=%h exp=%h", data_grid, C_GRID); n_err++; end
      run_x(301, 302, 303);
      n_vec++; if (data_grid !== 16'h0) begin $display("FAIL blank_302_301 got=%h exp=0000", data_grid); n_err++; end
   endtask

   task automatic test_hgrid;
      lines(44, 108); run_x(108, 44, 300);
      n_vec++; if (data_grid !== 16'h0) begin $display("FAIL hgrid_299 got=%h exp=0000", data_grid); n_err++; end
      step(301, 108);
      n_vec++; if (data_grid !== C_GRID || grid_hit !== 1'b1) begin $display("FAIL hgrid_300 got=%h/%b exp=%h/1", data_grid, grid_hit, C_GRID); n_err++; end
      run_x(108, 302, 601);
      n_vec++; if (data_grid !== 16'h0) begin $display("FAIL hgrid_600 got=%h exp=0000", data_grid); n_err++; end
   endtask

   task automatic test_cursor;
      cur_x = 12'd100; cur_y = 12'd200; cur_on = 1'b1; cur_wr = 1'b1;
      step(0, 10);
      n_vec++; if (cur_pend !== 1'b1) begin $display("FAIL cur_pend_set got=%b exp=1", cur_pend); n_err++; end
      lines(44, 50); run_x(50, 44, 145);
      n_vec++; if (data_grid !== 16'h0) begin $display("FAIL cur_not_yet got=%h exp=0000", data_grid); n_err++; end
      step(0, 0);
      n_vec++; if (cur_pend !== 1'b0) begin $display("FAIL cur_pend_clr got=%b exp=0", cur_pend); n_err++; end
      lines(44, 50); run_x(50, 44, 145);
      n_vec++; if (data_grid !== C_CUR || grid_hit !== 1'b1) begin $display("FAIL cur_v_144_50 got=%h/%b exp=%h/1", data_grid, grid_hit, C_CUR); n_err++; end
      lines(51, 244); run_x(244, 44, 401);
      n_vec++; if (data_grid !== C_CUR) begin $display("FAIL cur_h_400_244 got=%h exp=%h", data_grid, C_CUR); n_err++; end
   endtask

   task automatic test_collisions;
      cur_x = 12'd10; cur_y = 12'd20; cur_on = 1'b1; cur_wr = 1'b1;
      step(0, 0);
      n_vec++; if (cur_pend !== 1'b0) begin $display("FAIL coinc_pend got=%b exp=0", cur_pend); n_err++; end
      lines(44, 50); run_x(50, 44, 55);
      n_vec++; if (data_grid !== C_CUR) begin $display("FAIL coinc_54_50 got=%h exp=%h", data_grid, C_CUR); n_err++; end
      cur_x = 12'd10; cur_wr = 1'b1; step(0, 51);
      cur_x = 12'd600; cur_y = 12'd20; cur_wr = 1'b1; step(0, 52);
      n_vec++; if (cur_pend !== 1'b1) begin $display("FAIL lastwr_pend got=%b exp=1", cur_pend); n_err++; end
      step(0, 0);
      lines(44, 50); run_x(50, 44, 55);
      n_vec++; if (data_grid !== 16'h0) begin $display("FAIL novert_54_50 got=%h exp=0000", data_grid); n_err++; end
      lines(51, 64); run_x(64, 44, 61);
      n_vec++; if (data_grid !== C_CUR) begin $display("FAIL horiz_60_64 got=%h exp=%h", data_grid, C_CUR); n_err++; end
   endtask

   task automatic test_axis;
      logic [15:0] exp_c, exp_t;
`ifdef GRID_CENTER_AXIS_EN
      exp_c = C_AXIS; exp_t = C_AXIS;
`else
      exp_c = C_GRID; exp_t = 16'h0;
`endif
      step(0, 0);
      lines(44, 300); run_x(300, 44, 301);
      n_vec++; if (data_grid !== exp_c) begin $display("FAIL axis_300_300 got=%h exp=%h", data_grid, exp_c); n_err++; end
      lines(301, 316); run_x(316, 44, 299);
      n_vec++; if (data_grid !== exp_t) begin $display("FAIL tick_298_316 got=%h exp=%h", data_grid, exp_t); n_err++; end
   endtask

   task automatic test_reset_mid_frame;
      step(0, 0);
      lines(44, 63);
      cur_x = 12'd5; cur_y = 12'd5; cur_on = 1'b1; cur_wr = 1'b1;
      step(0, 64);
      n_vec++; if (cur_pend !== 1'b1) begin $display("FAIL mrst_pend_pre got=%b exp=1", cur_pend); n_err++; end
      run_x(64, 44, 61);
      n_vec++; if (data_grid !== C_CUR) begin $display("FAIL mrst_pre_60_64 got=%h exp=%h", data_grid, C_CUR); n_err++; end
      rst_grid = 1'b1;
      step(62, 64);
      n_vec++; if (data_grid !== 16'h0 || grid_hit !== 1'b0 || cur_pend !== 1'b0) begin $display("FAIL mrst_out got=%h/%b/%b exp=0000/0/0", data_grid, grid_hit, cur_pend); n_err++; end
      step(63, 64); step(64, 64);
      rst_grid = 1'b0;
      step(0, 0);
      lines(44, 64); run_x(64, 44, 61);
      n_vec++; if (data_grid !== 16'h0) begin $display("FAIL mrst_cur_off got=%h exp=0000", data_grid); n_err++; end
   endtask

   initial begin
      rst_grid = 1'b1;
      xpos_grid = '0; ypos_grid = '0;
      color_grid = C_GRID; color_back = C_BACK; color_cur = C_CUR; color_axis = C_AXIS;
      cur_wr = 1'b0; cur_x = '0; cur_y = '0; cur_on = 1'b0;
      test_reset();
      test_scan();
      test_hgrid();
      test_cursor();
      test_collisions();
      test_axis();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
